// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared definitions for responders on the core IO bus.
//   - IO bus command encodings (control_out_io)
//   - UART transmit / receive state encodings
//   - Bit positions of the UART STATUS register
package io_bus_pkg;

   localparam logic [1:0] IO_CMD_IDLE  = 2'b00;
   localparam logic [1:0] IO_CMD_READ  = 2'b01;
   localparam logic [1:0] IO_CMD_WRITE = 2'b10;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   localparam int ST_TX_FULL     = 0;
   localparam int ST_TX_EMPTY    = 1;
   localparam int ST_RX_NONEMPTY = 2;
   localparam int ST_RX_OVERRUN  = 3;
   localparam int ST_TX_BUSY     = 4;
   localparam int ST_TX_DROP     = 5;
   localparam int ST_FRAME_ERR   = 6;

endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: 8-bit synchronous first-word-fall-through FIFO.
// Ports:
//   main_clk, reset_n : clock and asynchronous active-low reset
//   push, din         : write request and data (accepted when not full,
//                       or when full but popped in the same cycle)
//   pop               : remove the head entry (ignored when empty)
//   dout              : head entry, valid whenever empty is low
//   full, empty       : occupancy flags
module io_uart_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       main_clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   // One extra pointer bit distinguishes full from empty when the
   // address bits coincide.
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic [7:0]  mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge main_clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge main_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

endmodule

// File: rtl/io_uart.sv
// io_uart: 8N1 UART responder on the core IO bus.
// Register window: BASE_ADDR = DATA (read pops RX byte, write pushes TX byte),
//                  BASE_ADDR+1 = STATUS (read clears sticky flags).
// Ports:
//   main_clk, reset_n : clock and asynchronous active-low reset
//   data_out_io       : write data from the core (low byte used)
//   address_out_io    : IO address from the core
//   control_out_io    : bus command (idle / read / write)
//   data_in_io        : registered read data, 0 when not responding
//   uart_tx           : serial output, idle high
//   uart_rx           : serial input, asynchronous to main_clk
module io_uart
   import io_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
   parameter int          CLKS_PER_BIT = 781,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        main_clk,
   input  logic        reset_n,
   input  logic [15:0] data_out_io,
   input  logic [31:0] address_out_io,
   input  logic [1:0]  control_out_io,
   output logic [15:0] data_in_io,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int          CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = 1;

   // ---------------- bus decode ----------------
   logic hit, rd_data, rd_stat, wr_data;
   logic unused_data_hi;

   assign hit     = (address_out_io[31:1] == BASE_ADDR[31:1]);
   assign rd_data = hit && (control_out_io == IO_CMD_READ)  && !address_out_io[0];
   assign rd_stat = hit && (control_out_io == IO_CMD_READ)  &&  address_out_io[0];
   assign wr_data = hit && (control_out_io == IO_CMD_WRITE) && !address_out_io[0];
   assign unused_data_hi = &{1'b0, data_out_io[15:8]};

   // ---------------- FIFOs ----------------
   logic       tx_pop, tx_full, tx_empty;
   logic [7:0] tx_dout;
   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] rx_dout;
   logic [7:0] rx_shift_reg, rx_shift_next;

   assign rx_pop = rd_data && !rx_empty;

   io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .main_clk (main_clk),
      .reset_n  (reset_n),
      .push     (wr_data),
      .pop      (tx_pop),
      .din      (data_out_io[7:0]),
      .dout     (tx_dout),
      .full     (tx_full),
      .empty    (tx_empty)
   );

   io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .main_clk (main_clk),
      .reset_n  (reset_n),
      .push     (rx_push),
      .pop      (rx_pop),
      .din      (rx_shift_reg),
      .dout     (rx_dout),
      .full     (rx_full),
      .empty    (rx_empty)
   );

   // ---------------- transmitter ----------------
   tx_state_t     tx_state_reg, tx_state_next;
   logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
   logic [2:0]    tx_bit_reg, tx_bit_next;
   logic [7:0]    tx_shift_reg, tx_shift_next;

   always_ff @(posedge main_clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
      end
   end

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg + CNT_ONE;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      tx_pop        = 1'b0;
      case (tx_state_reg)
         TX_IDLE: begin
            tx_cnt_next = '0;
            if (!tx_empty) begin
               tx_pop        = 1'b1;
               tx_shift_next = tx_dout;
               tx_state_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_reg == BIT_LAST) begin
               tx_cnt_next   = '0;
               tx_bit_next   = '0;
               tx_state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt_reg == BIT_LAST) begin
               tx_cnt_next   = '0;
               tx_shift_next = {1'b0, tx_shift_reg[7:1]};
               tx_bit_next   = tx_bit_reg + 3'd1;
               if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_cnt_reg == BIT_LAST) begin
               tx_cnt_next   = '0;
               tx_state_next = TX_IDLE;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase
   end

   // Decoded straight from flops so an asynchronous reset forces the line
   // high without waiting for a clock edge.
   always_comb begin
      uart_tx = 1'b1;
      if (tx_state_reg == TX_START)     uart_tx = 1'b0;
      else if (tx_state_reg == TX_DATA) uart_tx = tx_shift_reg[0];
   end

   // ---------------- receiver ----------------
   logic [1:0]    rx_sync_reg;
   logic          rx_s;
   rx_state_t     rx_state_reg, rx_state_next;
   logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]    rx_bit_reg, rx_bit_next;
   logic          frame_err_set;

   assign rx_s = rx_sync_reg[1];

   always_ff @(posedge main_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync_reg  <= 2'b11;
         rx_state_reg <= RX_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
      end else begin
         rx_sync_reg  <= {rx_sync_reg[0], uart_rx};
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg + CNT_ONE;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_push       = 1'b0;
      frame_err_set = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            rx_cnt_next = '0;
            if (!rx_s) rx_state_next = RX_START;
         end
         RX_START: begin
            // Mid-start resample; subsequent samples land mid-bit.
            if (rx_cnt_reg == HALF_LAST) begin
               rx_cnt_next   = '0;
               rx_bit_next   = '0;
               rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_reg == BIT_LAST) begin
               rx_cnt_next   = '0;
               rx_shift_next = {rx_s, rx_shift_reg[7:1]};
               rx_bit_next   = rx_bit_reg + 3'd1;
               if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_reg == BIT_LAST) begin
               rx_cnt_next = '0;
               if (rx_s) begin
                  rx_push       = 1'b1;
                  rx_state_next = RX_IDLE;
               end else begin
                  frame_err_set = 1'b1;
                  rx_state_next = RX_WAIT_HIGH;
               end
            end
         end
         RX_WAIT_HIGH: begin
            rx_cnt_next = '0;
            if (rx_s) rx_state_next = RX_IDLE;
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   // ---------------- sticky flags and read data ----------------
   logic        rx_overrun_reg, tx_drop_reg, frame_err_reg;
   logic        rx_overrun_set, tx_drop_set;
   logic [15:0] status_vec;
   logic [15:0] data_in_reg, data_in_next;

   assign rx_overrun_set = rx_push && rx_full && !rx_pop;
   assign tx_drop_set    = wr_data && tx_full && !tx_pop;

   always_comb begin
      status_vec                 = '0;
      status_vec[ST_TX_FULL]     = tx_full;
      status_vec[ST_TX_EMPTY]    = tx_empty;
      status_vec[ST_RX_NONEMPTY] = !rx_empty;
      status_vec[ST_RX_OVERRUN]  = rx_overrun_reg;
      status_vec[ST_TX_BUSY]     = (tx_state_reg != TX_IDLE);
      status_vec[ST_TX_DROP]     = tx_drop_reg;
      status_vec[ST_FRAME_ERR]   = frame_err_reg;
   end

   always_comb begin
      data_in_next = '0;
      if (rx_pop)  data_in_next = {7'b0, 1'b1, rx_dout};
      if (rd_stat) data_in_next = status_vec;
   end

   always_ff @(posedge main_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_overrun_reg <= 1'b0;
         tx_drop_reg    <= 1'b0;
         frame_err_reg  <= 1'b0;
         data_in_reg    <= '0;
      end else begin
         // A set in the same cycle as the clearing read wins.
         rx_overrun_reg <= rx_overrun_set | (rx_overrun_reg & ~rd_stat);
         tx_drop_reg    <= tx_drop_set    | (tx_drop_reg    & ~rd_stat);
         frame_err_reg  <= frame_err_set  | (frame_err_reg  & ~rd_stat);
         data_in_reg    <= data_in_next;
      end
   end

   assign data_in_io = data_in_reg;

endmodule

// File: tb/tb_io_uart.sv
module tb_io_uart;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam int CPB   = 4;
   localparam int DEPTH = 16;

   logic        clk;
   logic        reset_n;
   logic [15:0] data_out_io;
   logic [31:0] address_out_io;
   logic [1:0]  control_out_io;
   logic [15:0] data_in_io;
   logic        uart_tx;
   logic        uart_rx;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mon_q[$];   // bytes decoded from uart_tx
   logic [7:0] rx_model[$];

   io_uart #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .main_clk       (clk),
      .reset_n        (reset_n),
      .data_out_io    (data_out_io),
      .address_out_io (address_out_io),
      .control_out_io (control_out_io),
      .data_in_io     (data_in_io),
      .uart_tx        (uart_tx),
      .uart_rx        (uart_rx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic bus_read(input logic a0, output logic [15:0] d);
      address_out_io = BASE | {31'b0, a0};
      control_out_io = 2'b01;
      @(negedge clk);
      d = data_in_io;
      control_out_io = 2'b00;
   endtask

   task automatic bus_write(input logic [15:0] v);
      address_out_io = BASE;
      data_out_io    = v;
      control_out_io = 2'b10;
      @(negedge clk);
      control_out_io = 2'b00;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         uart_rx = b[k];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Line decoder: finds a start bit, samples each bit in its middle.
   initial begin
      logic [7:0] mb;
      logic       ok;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            ok = (uart_tx === 1'b0);
            for (int k = 0; k < 8; k++) begin
               repeat (CPB) @(negedge clk);
               mb[k] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (ok && uart_tx === 1'b1) mon_q.push_back(mb);
         end
      end
   end

   initial begin
      logic [15:0] d;
      logic [15:0] exp;
      logic [7:0]  tx_bytes [18];
      logic [7:0]  b;
      logic        ovr;
      int          cyc;

      reset_n = 1'b0;
      uart_rx = 1'b1;
      control_out_io = 2'b00;
      address_out_io = '0;
      data_out_io = '0;
      repeat (3) @(negedge clk);
      check("reset_tx", {15'b0, uart_tx}, 16'h0001);
      check("reset_rd", data_in_io, 16'h0000);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(1'b1, d);
      check("stat_reset", d, 16'h0002);
      @(negedge clk);
      check("rd_back_to_0", data_in_io, 16'h0000);

      // Single byte 0x55: exact line waveform, busy seen mid-frame.
      mon_q.delete();
      bus_write(16'h0055);
      check("tx_before_start", {15'b0, uart_tx}, 16'h0001);
      b = 8'h55;
      for (int i = 0; i < 44; i++) begin
         @(negedge clk);
         if (i == 6) begin
            check("stat_busy", data_in_io, 16'h0012);
            control_out_io = 2'b00;
         end
         if (i < 4)       exp = 16'h0000;
         else if (i < 36) exp = {15'b0, b[(i - 4) / 4]};
         else             exp = 16'h0001;
         check($sformatf("tx_wave%0d", i), {15'b0, uart_tx}, exp);
         if (i == 5) begin
            address_out_io = BASE + 32'd1;
            control_out_io = 2'b01;
         end
      end
      repeat (4) @(negedge clk);
      check("tx55_count", 16'(mon_q.size()), 16'd1);
      if (mon_q.size() > 0) check("tx55_byte", {8'h0, mon_q[0]}, 16'h0055);

      // One received frame, non-hit and ignored commands leave it in place.
      send_rx(8'hA3, 1'b1);
      bus_read(1'b1, d);
      check("stat_rx1", d, 16'h0006);
      address_out_io = BASE + 32'd2;
      control_out_io = 2'b01;
      @(negedge clk);
      control_out_io = 2'b00;
      check("nonhit_rd", data_in_io, 16'h0000);
      address_out_io = BASE;
      control_out_io = 2'b11;
      @(negedge clk);
      control_out_io = 2'b00;
      check("cmd11_rd", data_in_io, 16'h0000);
      bus_read(1'b0, d);
      check("rx_A3", d, 16'h01A3);
      bus_read(1'b0, d);
      check("rx_empty_rd", d, 16'h0000);
      bus_read(1'b1, d);
      check("stat_after_rx", d, 16'h0002);

      // TX overflow: the first byte leaves the FIFO at once, so DEPTH+1 fit.
      mon_q.delete();
      for (int i = 0; i < 18; i++) begin
         tx_bytes[i] = 8'($urandom_range(0, 255));
         address_out_io = BASE;
         data_out_io = {8'($urandom), tx_bytes[i]};
         control_out_io = 2'b10;
         @(negedge clk);
      end
      bus_read(1'b1, d);
      check("stat_drop", d, 16'h0031);
      bus_read(1'b1, d);
      check("stat_drop_clr", d, 16'h0011);
      cyc = 0;
      while (mon_q.size() < DEPTH + 1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("tx_burst_count", 16'(mon_q.size()), 16'(DEPTH + 1));
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (i < mon_q.size()) check($sformatf("tx_burst%0d", i), {8'h0, mon_q[i]}, {8'h0, tx_bytes[i]});
      end
      repeat (10) @(negedge clk);
      bus_read(1'b1, d);
      check("stat_tx_done", d, 16'h0002);

      // RX overflow against a queue model.
      rx_model.delete();
      ovr = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom_range(0, 255));
         send_rx(b, 1'b1);
         if (rx_model.size() < DEPTH) rx_model.push_back(b);
         else ovr = 1'b1;
      end
      bus_read(1'b1, d);
      check("stat_overrun", d, {12'h0, ovr, 3'b110});
      for (int i = 0; i < DEPTH + 1; i++) begin
         bus_read(1'b0, d);
         if (rx_model.size() > 0) exp = {8'h01, rx_model.pop_front()};
         else exp = 16'h0000;
         check($sformatf("rx_read%0d", i), d, exp);
      end
      bus_read(1'b1, d);
      check("stat_rx_drained", d, 16'h0002);

      // Glitch, then a frame with a low stop bit.
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (10) @(negedge clk);
      bus_read(1'b1, d);
      check("stat_glitch", d, 16'h0002);
      bus_read(1'b0, d);
      check("rd_glitch", d, 16'h0000);
      send_rx(8'($urandom_range(0, 255)), 1'b0);
      bus_read(1'b1, d);
      check("stat_frame_err", d, 16'h0042);
      bus_read(1'b0, d);
      check("rd_frame_err", d, 16'h0000);
      bus_read(1'b1, d);
      check("stat_ferr_clr", d, 16'h0002);

      // Reset in the middle of a transmitted zero byte.
      bus_write(16'h0000);
      repeat (12) @(negedge clk);
      check("tx_mid_low", {15'b0, uart_tx}, 16'h0000);
      #2 reset_n = 1'b0;
      #1 check("tx_reset_high", {15'b0, uart_tx}, 16'h0001);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(1'b1, d);
      check("stat_post_reset", d, 16'h0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
